// File: rtl/wt_cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the write-through cache controller slice:
//   - state_t      : controller FSM states
//   - DEF_*        : default widths used as parameter defaults
//   - line_index() : extracts the line index field from a word address
// ---------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_INDEX_BITS = 4;
    localparam int DEF_ADDR_LSB   = 1;
    localparam int DEF_CNT_WIDTH  = 16;

    // The address is passed zero-extended to 64 bits so one function serves
    // every parameterisation; callers cast the result down to INDEX_BITS.
    function automatic int unsigned line_index(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned bits);
        logic [63:0] mask;
        mask = (64'd1 << bits) - 64'd1;
        return 32'((addr >> lsb) & mask);
    endfunction

endpackage

// File: rtl/wt_cache_ctrl_if.sv
// ---------------------------------------------------------------------------
// wt_cache_ctrl_if
// Request/acknowledge word bus used on both sides of the cache.
//   req   : request, held by the master until ack
//   we    : 1 = write, 0 = read
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid with ack
//   ack   : one-cycle completion
// On the CPU side the cache is the slave (ack is cpu_done, rdata is
// cpu_rdata); on the memory side the cache is the master.
// ---------------------------------------------------------------------------
interface wt_cache_ctrl_if
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/wt_cache_ctrl_line_array.sv
// ---------------------------------------------------------------------------
// cache_line_array
// Valid/tag/data storage for a direct-mapped cache, one word per line.
//   clk, rst  : clock, synchronous active-high reset (clears valid bits)
//   clear_all : invalidate every line this cycle
//   rd_idx    : asynchronous read index -> rd_valid, rd_tag, rd_data
//   wr_en     : write wr_tag/wr_data to line wr_idx and mark it valid
// ---------------------------------------------------------------------------
module cache_line_array
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_all,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [ADDR_WIDTH-1:0] wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid;
    logic [ADDR_WIDTH-1:0] tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    // Valid bits are the only state that needs resetting; a global clear
    // wins over a simultaneous write so a flush really empties the cache.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless while valid is 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/wt_cache_ctrl.sv
// ---------------------------------------------------------------------------
// wt_cache_ctrl
// Direct-mapped, write-through, no-write-allocate cache controller.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : single-cycle invalidate-all request (honoured in IDLE only)
//   cpu       : CPU-side bus (slave); cpu.ack is the cpu_done pulse
//   mem       : memory-side bus (master); req held until mem.ack
//   hit       : registered, valid together with cpu.ack
//   hit_cnt   : saturating hit counter
//   miss_cnt  : saturating miss counter
// ---------------------------------------------------------------------------
module wt_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int ADDR_LSB   = DEF_ADDR_LSB,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    wt_cache_ctrl_if.slave       cpu,
    wt_cache_ctrl_if.master      mem,
    output logic                 hit,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  store_hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  done_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic [INDEX_BITS-1:0] line_idx;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  lookup_hit;
    logic                  accept;
    logic                  clear_all;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    assign line_idx   = INDEX_BITS'(line_index(64'(addr_q), ADDR_LSB, INDEX_BITS));
    // The tag holds the whole address, so a match cannot alias.
    assign lookup_hit = rd_valid && (rd_tag == addr_q);
    // done_q blocks re-capturing the request the CPU is still holding in
    // the cycle its completion pulse is visible.
    assign accept     = (state_q == IDLE) && !flush && cpu.req && !done_q;
    assign clear_all  = (state_q == IDLE) && flush;
    // Load fills always allocate; stores only refresh a line already present.
    assign wr_en      = mem.ack && ((state_q == MEM_RD) ||
                                    ((state_q == MEM_WR) && store_hit_q));
    assign wr_data    = (state_q == MEM_RD) ? mem.rdata : wdata_q;

    cache_line_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .clear_all (clear_all),
        .rd_idx    (line_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (line_idx),
        .wr_tag    (addr_q),
        .wr_data   (wr_data)
    );

    assign cpu.rdata = rdata_q;
    assign cpu.ack   = done_q;
    assign mem.req   = mem_req_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a load hit returns straight to IDLE, everything
    // else goes out to memory and waits for the ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    state_d = MEM_WR;
                end else if (lookup_hit) begin
                    state_d = IDLE;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem.ack) begin
                    state_d = IDLE;
                end
            end
            MEM_WR: begin
                if (mem.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers, memory request outputs and statistics. done and
    // hit are single-cycle pulses, so they default to 0 every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            store_hit_q <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            hit         <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            hit    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= cpu.addr;
                        we_q    <= cpu.we;
                        wdata_q <= cpu.wdata;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= wdata_q;
                        store_hit_q <= lookup_hit;
                        if (lookup_hit) begin
                            hit_cnt <= (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;
                        end else begin
                            miss_cnt <= (&miss_cnt) ? miss_cnt : miss_cnt + 1'b1;
                        end
                    end else if (lookup_hit) begin
                        rdata_q <= rd_data;
                        hit     <= 1'b1;
                        done_q  <= 1'b1;
                        hit_cnt <= (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= addr_q;
                        miss_cnt   <= (&miss_cnt) ? miss_cnt : miss_cnt + 1'b1;
                    end
                end
                MEM_RD: begin
                    if (mem.ack) begin
                        rdata_q   <= mem.rdata;
                        done_q    <= 1'b1;
                        mem_req_q <= 1'b0;
                    end
                end
                MEM_WR: begin
                    if (mem.ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        hit       <= store_hit_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wt_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wt_cache_ctrl
// Directed bench for wt_cache_ctrl with a behavioural memory whose ack
// latency is adjustable between transactions.
// ---------------------------------------------------------------------------
module tb_wt_cache_ctrl;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          hit;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    wt_cache_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_bus ();
    wt_cache_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    wt_cache_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INDEX_BITS (4),
        .ADDR_LSB   (1),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .cpu      (cpu_bus),
        .mem      (mem_bus),
        .hit      (hit),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Memory model state and observation log.
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            mem_latency = 2;
    int            wait_cnt    = 0;
    int            req_cycles  = 0;
    int            done_pulses = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    // Transaction results.
    logic          got_done;
    int            lat;
    logic [DW-1:0] res_rdata;
    logic          res_hit;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Behavioural memory: acks after mem_latency idle cycles of a held
    // request, performs the access on the ack, and logs what it saw.
    always @(negedge clk) begin
        if (cpu_bus.ack) done_pulses++;
        if (rst) begin
            mem_bus.ack = 1'b0;
            wait_cnt    = 0;
        end else if (mem_bus.ack) begin
            mem_bus.ack = 1'b0;
        end else if (mem_bus.req) begin
            req_cycles++;
            if (wait_cnt >= mem_latency) begin
                mem_bus.ack = 1'b1;
                wait_cnt    = 0;
                if (mem_bus.we) begin
                    mem_model[mem_bus.addr] = mem_bus.wdata;
                    last_wr_addr = mem_bus.addr;
                    last_wr_data = mem_bus.wdata;
                end else begin
                    mem_bus.rdata = mem_model.exists(mem_bus.addr) ? mem_model[mem_bus.addr] : '0;
                    last_rd_addr  = mem_bus.addr;
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    // Issue one CPU access (optionally with a coincident flush pulse) and
    // wait, bounded, for its completion pulse.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic with_flush);
        @(negedge clk);
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = we;
        cpu_bus.addr  = addr;
        cpu_bus.wdata = wdata;
        flush         = with_flush;
        got_done      = 1'b0;
        lat           = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            flush = 1'b0;
            if (cpu_bus.ack) begin
                got_done  = 1'b1;
                lat       = cyc;
                res_rdata = cpu_bus.rdata;
                res_hit   = hit;
                break;
            end
        end
        cpu_bus.req = 1'b0;
        cpu_bus.we  = 1'b0;
        if (!got_done) checkOutput("done timeout", 64'(got_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        int d0;
        rst           = 1'b1;
        flush         = 1'b0;
        cpu_bus.req   = 1'b0;
        cpu_bus.we    = 1'b0;
        cpu_bus.addr  = '0;
        cpu_bus.wdata = '0;
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = '0;
        mem_model[28'h11E] = 32'h7800_0000;
        mem_model[28'h13E] = 32'hCAFE_013E;
        mem_model[28'h120] = 32'h1201_2012;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset done", 64'(cpu_bus.ack), 64'd0);
        checkOutput("reset hit", 64'(hit), 64'd0);
        checkOutput("reset rdata", 64'(cpu_bus.rdata), 64'd0);
        checkOutput("reset mem_req", 64'(mem_bus.req), 64'd0);
        checkOutput("reset hit_cnt", 64'(hit_cnt), 64'd0);
        checkOutput("reset miss_cnt", 64'(miss_cnt), 64'd0);
        rst = 1'b0;

        // 1: cold load miss, memory latency 2.
        applyStimulus(1'b0, 28'h11E, '0, 1'b0);
        checkOutput("t1 mem addr", 64'(last_rd_addr), 64'h11E);
        checkOutput("t1 rdata", 64'(res_rdata), 64'h7800_0000);
        checkOutput("t1 hit", 64'(res_hit), 64'd0);
        checkOutput("t1 latency", 64'(lat), 64'd5);
        checkOutput("t1 miss_cnt", 64'(miss_cnt), 64'd1);

        // 2: repeat load hits without touching memory.
        r0 = req_cycles;
        applyStimulus(1'b0, 28'h11E, '0, 1'b0);
        checkOutput("t2 latency", 64'(lat), 64'd2);
        checkOutput("t2 hit", 64'(res_hit), 64'd1);
        checkOutput("t2 rdata", 64'(res_rdata), 64'h7800_0000);
        checkOutput("t2 mem_req cycles", 64'(req_cycles - r0), 64'd0);
        checkOutput("t2 hit_cnt", 64'(hit_cnt), 64'd1);

        // 3: store hit writes through and updates the line.
        applyStimulus(1'b1, 28'h11E, 32'h5, 1'b0);
        checkOutput("t3 store hit", 64'(res_hit), 64'd1);
        checkOutput("t3 store latency", 64'(lat), 64'd5);
        checkOutput("t3 wr addr", 64'(last_wr_addr), 64'h11E);
        checkOutput("t3 wr data", 64'(last_wr_data), 64'h5);
        checkOutput("t3 hit_cnt", 64'(hit_cnt), 64'd2);
        applyStimulus(1'b0, 28'h11E, '0, 1'b0);
        checkOutput("t3 reload hit", 64'(res_hit), 64'd1);
        checkOutput("t3 reload rdata", 64'(res_rdata), 64'h5);
        checkOutput("t3 miss_cnt", 64'(miss_cnt), 64'd1);

        // 4: flush, then same-index conflict evicts.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(1'b0, 28'h11E, '0, 1'b0);
        checkOutput("t4 11E after flush hit", 64'(res_hit), 64'd0);
        checkOutput("t4 11E rdata", 64'(res_rdata), 64'h5);
        applyStimulus(1'b0, 28'h13E, '0, 1'b0);
        checkOutput("t4 13E hit", 64'(res_hit), 64'd0);
        checkOutput("t4 13E rdata", 64'(res_rdata), 64'hCAFE_013E);
        applyStimulus(1'b0, 28'h11E, '0, 1'b0);
        checkOutput("t4 11E evicted hit", 64'(res_hit), 64'd0);
        checkOutput("t4 miss_cnt", 64'(miss_cnt), 64'd4);
        applyStimulus(1'b0, 28'h120, '0, 1'b0);
        applyStimulus(1'b0, 28'h120, '0, 1'b0);
        checkOutput("t4 120 cached hit", 64'(res_hit), 64'd1);
        checkOutput("t4 hit_cnt", 64'(hit_cnt), 64'd4);

        // 5: flush coincident with a request delays acceptance by a cycle.
        applyStimulus(1'b0, 28'h120, '0, 1'b1);
        checkOutput("t5 latency", 64'(lat), 64'd6);
        checkOutput("t5 hit", 64'(res_hit), 64'd0);
        checkOutput("t5 rdata", 64'(res_rdata), 64'h1201_2012);
        checkOutput("t5 miss_cnt", 64'(miss_cnt), 64'd6);

        // Zero-wait memory gives the minimum miss latency.
        mem_latency = 0;
        applyStimulus(1'b0, 28'h13E, '0, 1'b0);
        checkOutput("zw latency", 64'(lat), 64'd3);
        checkOutput("zw rdata", 64'(res_rdata), 64'hCAFE_013E);
        checkOutput("zw miss_cnt", 64'(miss_cnt), 64'd7);

        // Store miss is no-write-allocate.
        mem_latency = 1;
        applyStimulus(1'b1, 28'h160, 32'hDEAD_BEEF, 1'b0);
        checkOutput("sm hit", 64'(res_hit), 64'd0);
        checkOutput("sm latency", 64'(lat), 64'd4);
        checkOutput("sm wr addr", 64'(last_wr_addr), 64'h160);
        checkOutput("sm miss_cnt", 64'(miss_cnt), 64'd8);
        applyStimulus(1'b0, 28'h120, '0, 1'b0);
        checkOutput("sm 120 kept hit", 64'(res_hit), 64'd1);
        checkOutput("sm 120 rdata", 64'(res_rdata), 64'h1201_2012);
        applyStimulus(1'b0, 28'h160, '0, 1'b0);
        checkOutput("sm 160 not allocated", 64'(res_hit), 64'd0);
        checkOutput("sm 160 rdata", 64'(res_rdata), 64'hDEAD_BEEF);

        // 6: reset while a read is outstanding.
        mem_latency = 10;
        @(negedge clk);
        cpu_bus.req  = 1'b1;
        cpu_bus.we   = 1'b0;
        cpu_bus.addr = 28'h140;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6 mem_req before rst", 64'(mem_bus.req), 64'd1);
        d0  = done_pulses;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6 mem_req after rst", 64'(mem_bus.req), 64'd0);
        checkOutput("t6 hit_cnt", 64'(hit_cnt), 64'd0);
        checkOutput("t6 miss_cnt", 64'(miss_cnt), 64'd0);
        cpu_bus.req = 1'b0;
        rst         = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t6 no done", 64'(done_pulses - d0), 64'd0);
        mem_latency = 2;
        applyStimulus(1'b0, 28'h120, '0, 1'b0);
        checkOutput("t6 120 misses", 64'(res_hit), 64'd0);
        checkOutput("t6 120 rdata", 64'(res_rdata), 64'h1201_2012);
        checkOutput("t6 miss_cnt after", 64'(miss_cnt), 64'd1);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
